// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: MEM-stage data memory, valid/ready request, fixed-latency  |
// | response. Optional range check: DMEM_RANGE_CHECK_EN. Revision: 1.0         |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              request, accept, req_fault, load_rsp;
  logic              lat_wr, lat_fault, sel_wr, sel_fault;
  logic [IDX_W-1:0]  lat_idx, sel_idx, req_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign request = req_valid & (req_re | req_we);
  assign accept  = request & req_ready;
  assign req_idx = req_addr[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  generate
    if (ADDR_W > IDX_W) begin : g_range_chk
      assign req_fault = |req_addr[ADDR_W-1:IDX_W];
    end else begin : g_range_full
      assign req_fault = 1'b0;
    end
  endgenerate
`else
  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = |req_addr[ADDR_W-1:IDX_W];
    end
  endgenerate
  assign req_fault = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (request) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall releases in RESP so the pipeline advances on the edge that consumes the response.
  assign stall = (request & (state != RESP)) | (state == WAIT);

  // With LATENCY == 1 the response is loaded on the acceptance edge itself,
  // before the latched copy exists, so the live request is used instead.
  assign load_rsp  = (state_nxt == RESP) & (state != RESP);
  assign sel_wr    = (state == IDLE) ? req_we    : lat_wr;
  assign sel_fault = (state == IDLE) ? req_fault : lat_fault;
  assign sel_idx   = (state == IDLE) ? req_idx   : lat_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_wr    <= req_we;
        lat_fault <= req_fault;
        lat_idx   <= req_idx;
      end
      if (load_rsp) begin
        rsp_fault <= sel_fault;
        if (sel_wr)         rsp_rdata <= '0;
        else if (sel_fault) rsp_rdata <= '1;
        else                rsp_rdata <= mem[sel_idx];
      end else begin
        rsp_rdata <= '0;
        rsp_fault <= 1'b0;
      end
    end
  end

  // Storage is never reset; writes commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept & req_we & ~req_fault & ~rst) mem[req_idx] <= req_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Directed bench: three responders (LATENCY 2, 3, 1) share one request bus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_re = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        ready [3];
  logic        stl   [3];
  logic        valid [3];
  logic        fault [3];
  logic [15:0] rdata [3];

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[0]), .stall(stl[0]),
    .rsp_valid(valid[0]), .rsp_rdata(rdata[0]), .rsp_fault(fault[0]));
  dmem_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[1]), .stall(stl[1]),
    .rsp_valid(valid[1]), .rsp_rdata(rdata[1]), .rsp_fault(fault[1]));
  dmem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[2]), .stall(stl[2]),
    .rsp_valid(valid[2]), .rsp_rdata(rdata[2]), .rsp_fault(fault[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    end
  endtask

  // One request on instance d; checks handshake, latency and returns the response.
  task automatic do_op(input int d, input logic re, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input int lat,
                       output logic [15:0] data, output logic flt);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_re = re; req_we = we; req_addr = addr; req_wdata = wdata;
    #1;
    check($sformatf("ready_idle[%0d]", d), ready[d], 1);
    check($sformatf("stall_req[%0d]", d), stl[d], 1);
    @(negedge clk);
    req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    #1;
    k = 1;
    while (!valid[d] && k <= 20) begin
      @(negedge clk); #1;
      k++;
    end
    check($sformatf("latency[%0d]", d), k, lat);
    data = rdata[d];
    flt  = fault[d];
  endtask

  logic [15:0] d;
  logic        f;
  logic        seen;
  logic        exp_stall [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic        exp_ready [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        exp_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready[0], 1);
    check("rst_stall", stl[0], 0);
    check("rst_valid", valid[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_fault", fault[0], 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // LATENCY=2 write then read
    do_op(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2, d, f);
    check("wr_rdata", d, 0);
    check("wr_fault", f, 0);
    idle(1);
    do_op(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, d, f);
    check("rd_beef", d, 16'hBEEF);
    idle(6);

    // LATENCY=3, request held from cycle 0
    @(negedge clk);
    req_valid = 1'b1; req_re = 1'b1; req_addr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("hold_stall_c%0d", c), stl[1], exp_stall[c]);
      check($sformatf("hold_ready_c%0d", c), ready[1], exp_ready[c]);
      check($sformatf("hold_valid_c%0d", c), valid[1], exp_valid[c]);
      if (c == 3) check("hold_rdata", rdata[1], 16'hBEEF);
      @(negedge clk);
    end
    idle(6);

    // Both strobes: treated as a write
    do_op(0, 1'b1, 1'b1, 16'h0005, 16'h1234, 2, d, f);
    check("both_rdata", d, 0);
    idle(1);
    do_op(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2, d, f);
    check("both_readback", d, 16'h1234);
    idle(6);

    // Reset during WAIT of a read
    @(negedge clk);
    req_valid = 1'b1; req_re = 1'b1; req_addr = 16'h0005;
    @(negedge clk);
    req_valid = 1'b0; req_re = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_valid", valid[0], 0);
    check("rstw_ready", ready[0], 1);
    check("rstw_stall", stl[0], 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (valid[0]) seen = 1'b1;
      @(negedge clk);
    end
    check("rstw_no_pulse", seen, 0);
    check("rstw_ready_after", ready[0], 1);
    do_op(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2, d, f);
    check("rstw_new_read", d, 16'h1234);
    idle(6);

    // Out-of-range address
    do_op(0, 1'b0, 1'b1, 16'h0003, 16'h5555, 2, d, f);
    idle(1);
    do_op(0, 1'b0, 1'b1, 16'h1003, 16'hAAAA, 2, d, f);
    check("oor_wr_fault", f, RC);
    idle(1);
    do_op(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2, d, f);
    check("oor_mem3", d, RC ? 16'h5555 : 16'hAAAA);
    check("oor_mem3_fault", f, 0);
    idle(1);
    do_op(0, 1'b1, 1'b0, 16'h1003, 16'h0000, 2, d, f);
    check("oor_rd_data", d, RC ? 16'hFFFF : 16'hAAAA);
    check("oor_rd_fault", f, RC);
    idle(6);

    // LATENCY=1: valid without strobes is ignored
    @(negedge clk);
    req_valid = 1'b1; req_re = 1'b0; req_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("nostrobe_stall_c%0d", c), stl[2], 0);
      check($sformatf("nostrobe_valid_c%0d", c), valid[2], 0);
      check($sformatf("nostrobe_ready_c%0d", c), ready[2], 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    do_op(2, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, d, f);
    check("l1_rdata", d, 16'hBEEF);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
